// File: rtl/coffee_pkg.sv
// rtl/coffee_pkg.sv - shared drink codes and order states for the order controller and brewer
package coffee_pkg;

    typedef enum logic [1:0] {
        CF_E = 2'b00,
        CF_L = 2'b01,
        CF_C = 2'b10
    } coffee_t;

    typedef enum logic [2:0] {
        IDLE,
        CREDIT,
        DISPENSE,
        BREW,
        DRAIN
    } order_state_t;

    function automatic logic one_hot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage

// File: rtl/coffee_order_ctrl_if.sv
// rtl/coffee_order_ctrl_if.sv - button, brewer and payment signals of the order controller
interface coffee_order_ctrl_if #(
    parameter int CREDIT_W = 8
);
    import coffee_pkg::*;

    logic                btn_coin;
    logic [2:0]          btn_sel;
    logic                btn_cancel;
    logic                brew_done;
    logic                start;
    coffee_t             coffee_sel;
    logic [CREDIT_W-1:0] credit;
    logic                refund_valid;
    logic [CREDIT_W-1:0] refund_amt;
    logic                coin_reject;
    logic                err_funds;
    logic                busy;

    modport master (
        output btn_coin, btn_sel, btn_cancel, brew_done,
        input  start, coffee_sel, credit, refund_valid, refund_amt,
               coin_reject, err_funds, busy
    );

    modport slave (
        input  btn_coin, btn_sel, btn_cancel, brew_done,
        output start, coffee_sel, credit, refund_valid, refund_amt,
               coin_reject, err_funds, busy
    );

endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchronizer, stability counter and rising-edge event pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic rise_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q;

    // The counter only advances while the synchronized level disagrees with the accepted one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_q <= sync2_q;
                rise_q   <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/coffee_order_ctrl.sv
// rtl/coffee_order_ctrl.sv - coin/selection front end: credit, price check, brew handshake, refund
module coffee_order_ctrl
    import coffee_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int COIN_VALUE      = 5,
    parameter int PRICE_E         = 10,
    parameter int PRICE_L         = 15,
    parameter int PRICE_C         = 20,
    parameter int CREDIT_MAX      = 95,
    parameter int CREDIT_W        = 8,
    parameter int ERR_HOLD_CYCLES = 50_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    coffee_order_ctrl_if.slave   bus
);
    localparam int ERR_W = $clog2(ERR_HOLD_CYCLES + 1);

    logic [4:0] raw;
    logic [4:0] ev;
    assign raw = {bus.btn_cancel, bus.btn_sel, bus.btn_coin};

    for (genvar g = 0; g < 5; g++) begin : g_deb
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk    (clk),
            .reset  (reset),
            .btn_i  (raw[g]),
            .rise_o (ev[g])
        );
    end

    logic       coin_ev;
    logic [2:0] sel_ev;
    logic       cancel_ev;
    logic       sel_valid;
    assign coin_ev   = ev[0];
    assign sel_ev    = ev[3:1];
    assign cancel_ev = ev[4];
    assign sel_valid = one_hot3(sel_ev);

    order_state_t        state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] refund_amt_q, refund_amt_d;
    logic                refund_valid_q, refund_valid_d;
    logic                coin_reject_q, coin_reject_d;
    logic                start_q, start_d;
    coffee_t             sel_q, sel_d;
    logic                err_q, err_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;

    logic [CREDIT_W-1:0] price;
    coffee_t             sel_code;
    logic [CREDIT_W:0]   coin_sum;
    logic                err_set;
    logic                err_clr;

    always_comb begin
        price    = CREDIT_W'(PRICE_E);
        sel_code = CF_E;
        if (sel_ev[1]) begin
            price    = CREDIT_W'(PRICE_L);
            sel_code = CF_L;
        end else if (sel_ev[2]) begin
            price    = CREDIT_W'(PRICE_C);
            sel_code = CF_C;
        end
    end

    assign coin_sum = {1'b0, credit_q} + (CREDIT_W + 1)'(COIN_VALUE);

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        refund_amt_d   = refund_amt_q;
        refund_valid_d = 1'b0;
        coin_reject_d  = 1'b0;
        start_d        = 1'b0;
        sel_d          = sel_q;
        err_set        = 1'b0;
        err_clr        = 1'b0;
        case (state_q)
            IDLE: begin
                if (coin_ev) begin
                    credit_d = CREDIT_W'(COIN_VALUE);
                    err_clr  = 1'b1;
                    state_d  = CREDIT;
                end
            end
            CREDIT: begin
                // Priority: cancel, then a single selection, then coin.
                if (cancel_ev) begin
                    refund_valid_d = 1'b1;
                    refund_amt_d   = credit_q;
                    credit_d       = '0;
                    coin_reject_d  = coin_ev;
                    err_clr        = 1'b1;
                    state_d        = IDLE;
                end else if (sel_valid) begin
                    coin_reject_d = coin_ev;
                    if (price <= credit_q) begin
                        sel_d    = sel_code;
                        credit_d = credit_q - price;
                        start_d  = 1'b1;
                        state_d  = DISPENSE;
                    end else begin
                        err_set = 1'b1;
                    end
                end else if (coin_ev) begin
                    if (coin_sum <= (CREDIT_W + 1)'(CREDIT_MAX)) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        err_clr  = 1'b1;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            DISPENSE: begin
                coin_reject_d = coin_ev;
                if (bus.brew_done) state_d = BREW;
            end
            BREW: begin
                coin_reject_d = coin_ev;
                if (!bus.brew_done) state_d = DRAIN;
            end
            DRAIN: begin
                coin_reject_d = coin_ev;
                if (credit_q != '0) begin
                    refund_valid_d = 1'b1;
                    refund_amt_d   = credit_q;
                end
                credit_d = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (err_set) begin
            err_d     = 1'b1;
            err_cnt_d = ERR_W'(ERR_HOLD_CYCLES - 1);
        end else if (err_clr) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end else if (err_q) begin
            if (err_cnt_q == '0) err_d = 1'b0;
            else                 err_cnt_d = err_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            credit_q       <= '0;
            refund_amt_q   <= '0;
            refund_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            start_q        <= 1'b0;
            sel_q          <= CF_E;
            err_q          <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            refund_amt_q   <= refund_amt_d;
            refund_valid_q <= refund_valid_d;
            coin_reject_q  <= coin_reject_d;
            start_q        <= start_d;
            sel_q          <= sel_d;
            err_q          <= err_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign bus.start        = start_q;
    assign bus.coffee_sel   = sel_q;
    assign bus.credit       = credit_q;
    assign bus.refund_valid = refund_valid_q;
    assign bus.refund_amt   = refund_amt_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.err_funds    = err_q;
    assign bus.busy         = (state_q == DISPENSE) || (state_q == BREW) || (state_q == DRAIN);

endmodule
